// File: rtl/reg_display_scanner_pkg.sv
// Shared definitions for the register-file display scanner.
package reg_display_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_SHOW = 2'd3
    } state_t;

    localparam logic [1:0] PAGE_MSB = 2'd3;

endpackage

// File: rtl/reg_display_scanner_dwell_timer.sv
// Free-running dwell counter with synchronous clear and a terminal-count flag.
module dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Keep at least one bit so DWELL_CYCLES=1 still yields a legal counter.
    localparam int unsigned W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(DWELL_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/reg_display_scanner.sv
// Walks the register file through a debug read port and pages each 32-bit
// value, most significant byte first, onto a two-digit hex display.
module reg_display_scanner
    import reg_display_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              manual,
    input  logic              step,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [31:0]       rf_rd_data,
    output logic              disp_en,
    output logic [7:0]        disp_byte,
    output logic [ADDR_W-1:0] disp_idx,
    output logic [1:0]        disp_page
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        page;
    logic [31:0]       value;
    logic              dwell_tc;
    logic              dwell_clr;
    logic              advance;

    // Manual mode pins the dwell count at zero, so a switch back to auto starts a full dwell.
    assign advance   = en && (state == ST_SHOW) && (manual ? step : dwell_tc);
    assign dwell_clr = (state != ST_SHOW) || manual || advance;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr),
        .en  (1'b1),
        .tc  (dwell_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state_next = ST_READ;
                ST_READ: state_next = ST_CAPT;
                ST_CAPT: state_next = ST_SHOW;
                ST_SHOW: if (advance && (page == 2'd0)) state_next = ST_READ;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            page  <= PAGE_MSB;
            value <= '0;
        end else if (en && (state == ST_CAPT)) begin
            value <= rf_rd_data;
            page  <= PAGE_MSB;
        end else if (advance) begin
            if (page != 2'd0) begin
                page <= page - 2'd1;
            end else begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    always_comb begin
        rf_rd_en   = 1'b0;
        rf_rd_addr = '0;
        disp_en    = 1'b0;
        disp_byte  = '0;
        disp_idx   = '0;
        disp_page  = '0;
        if (state == ST_READ) begin
            rf_rd_en   = 1'b1;
            rf_rd_addr = idx;
        end
        if (state == ST_SHOW) begin
            disp_en   = 1'b1;
            disp_byte = value[{page, 3'b000} +: 8];
            disp_idx  = idx;
            disp_page = page;
        end
    end

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench for reg_display_scanner with a short dwell and a 1-cycle RF model.
module tb_reg_display_scanner;

    localparam int unsigned DWELL  = 4;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = 5;

    logic          clk;
    logic          rst;
    logic          en;
    logic          manual;
    logic          step;
    logic          rf_rd_en;
    logic [AW-1:0] rf_rd_addr;
    logic [31:0]   rf_rd_data;
    logic          disp_en;
    logic [7:0]    disp_byte;
    logic [AW-1:0] disp_idx;
    logic [1:0]    disp_page;

    int total = 0;
    int bad   = 0;

    reg_display_scanner #(
        .DWELL_CYCLES(DWELL),
        .NUM_REGS    (NREGS),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .manual     (manual),
        .step       (step),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .disp_en    (disp_en),
        .disp_byte  (disp_byte),
        .disp_idx   (disp_idx),
        .disp_page  (disp_page)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: synchronous read, one cycle of latency.
    always_ff @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= 32'hA0B1C200 | 32'(rf_rd_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rf_rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rf_rd_addr), 32'd0);
        chk({tag, "_disp_en"}, 32'(disp_en), 32'd0);
        chk({tag, "_byte"}, 32'(disp_byte), 32'd0);
        chk({tag, "_idx"}, 32'(disp_idx), 32'd0);
        chk({tag, "_page"}, 32'(disp_page), 32'd0);
    endtask

    task automatic chk_show(input string tag, input int a, input int p);
        logic [31:0] val;
        val = 32'hA0B1C200 | 32'(a);
        chk({tag, "_disp_en"}, 32'(disp_en), 32'd1);
        chk({tag, "_byte"}, 32'(disp_byte), 32'(val[8*p +: 8]));
        chk({tag, "_page"}, 32'(disp_page), 32'(p));
        chk({tag, "_idx"}, 32'(disp_idx), 32'(a));
    endtask

    // Entered in READ of register a; returns in READ of the next register.
    task automatic run_reg(input int a, input bit with_step);
        chk("read_en", 32'(rf_rd_en), 32'd1);
        chk("read_addr", 32'(rf_rd_addr), 32'(a));
        tick();
        chk("capt_rd_en", 32'(rf_rd_en), 32'd0);
        chk("capt_disp_en", 32'(disp_en), 32'd0);
        tick();
        for (int p = 3; p >= 0; p--) begin
            for (int c = 0; c < int'(DWELL); c++) begin
                if (with_step) step = c[0];
                chk_show("auto", a, p);
                tick();
            end
        end
        step = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; manual = 1'b0; step = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_all_zero("reset");
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("idle_rd_en", 32'(rf_rd_en), 32'd0);
        chk("idle_disp_en", 32'(disp_en), 32'd0);

        // Auto scan of all registers, then wrap to x0.
        en = 1'b1;
        tick();
        for (int a = 0; a < int'(NREGS); a++) run_reg(a, 1'b0);
        chk("wrap_rd_en", 32'(rf_rd_en), 32'd1);
        chk("wrap_addr", 32'(rf_rd_addr), 32'd0);
        run_reg(0, 1'b0);

        // Manual paging on x1.
        manual = 1'b1;
        tick(); tick();
        chk_show("man_first", 1, 3);
        repeat (100) begin
            tick();
            chk("man_frozen", 32'(disp_byte), 32'hA0);
        end
        step = 1'b1; tick(); step = 1'b0; chk_show("man_p2", 1, 2);
        step = 1'b1; tick(); step = 1'b0; chk_show("man_p1", 1, 1);
        step = 1'b1; tick(); step = 1'b0; chk_show("man_p0", 1, 0);
        step = 1'b1; tick(); step = 1'b0;
        chk("man_read_en", 32'(rf_rd_en), 32'd1);
        chk("man_read_addr", 32'(rf_rd_addr), 32'd2);
        tick(); tick();
        chk_show("man_new", 2, 3);

        // Step held high: one page per cycle, ignored in READ/CAPT.
        step = 1'b1;
        tick(); chk_show("held_p2", 2, 2);
        tick(); chk_show("held_p1", 2, 1);
        tick(); chk_show("held_p0", 2, 0);
        tick();
        chk("held_read_addr", 32'(rf_rd_addr), 32'd3);
        tick();
        chk("held_capt_disp", 32'(disp_en), 32'd0);
        tick(); chk_show("held_p3", 3, 3);
        tick(); chk_show("held_again_p2", 3, 2);
        step = 1'b0;
        repeat (3) begin tick(); chk_show("man_hold", 3, 2); end

        // Back to auto mid-page: full dwell before the next page.
        manual = 1'b0;
        repeat (3) begin tick(); chk_show("resume_p2", 3, 2); end
        tick(); chk_show("resume_p1", 3, 1);
        repeat (3) tick();
        tick(); chk_show("resume_p0", 3, 0);
        repeat (4) tick();
        run_reg(4, 1'b0);

        // Drop enable on page 1 of x5, then resume.
        tick(); tick();
        chk_show("x5_p3", 5, 3);
        repeat (4) tick();
        chk_show("x5_p2", 5, 2);
        repeat (4) tick();
        chk_show("x5_p1", 5, 1);
        en = 1'b0;
        tick();
        chk_all_zero("en_off");
        repeat (3) tick();
        chk("en_off_hold", 32'(rf_rd_en), 32'd0);
        en = 1'b1;
        tick();
        run_reg(5, 1'b0);

        // Asynchronous reset in the middle of SHOW.
        tick(); tick(); tick();
        chk_show("pre_rst", 6, 3);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        en = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();
        chk_all_zero("post_rst_idle");
        tick();
        chk("post_rst_idle2", 32'(rf_rd_en), 32'd0);
        en = 1'b1;
        tick();

        // Steps in auto mode must not disturb timing.
        run_reg(0, 1'b1);
        chk("step_ign_addr", 32'(rf_rd_addr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
